// File: rtl/imm_ext_pipe_if.sv
// rtl/imm_ext_pipe_if.sv - valid/ready bundle between decode, imm_ext_pipe and execute
interface imm_ext_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [24:0]      in_din;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  modport slave (
    input  flush, in_valid, in_op, in_din, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_err
  );

  modport master (
    output flush, in_valid, in_op, in_din, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_err
  );
endinterface

// File: rtl/imm_ext_pipe.sv
// rtl/imm_ext_pipe.sv - registered RV32/RV64 immediate extractor with 2-entry skid buffer
module imm_ext_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  imm_ext_pipe_if.slave bus
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $fatal(1, "imm_ext_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  // Occupancy: ONE = output register only, TWO = output plus skid.
  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

  occ_t             state, state_n;
  logic [XLEN-1:0]  out_imm_q, skid_imm_q;
  logic [TAG_W-1:0] out_tag_q, skid_tag_q;
  logic             out_err_q, skid_err_q;

  logic             accept, drain;
  logic             load_out_in, load_out_skid, load_skid;
  logic [XLEN-1:0]  ext_imm;
  logic             ext_err;

  assign bus.in_ready  = (state != TWO);
  assign bus.out_valid = (state != EMPTY);
  assign bus.out_imm   = out_imm_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_err   = out_err_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign drain  = bus.out_valid && bus.out_ready;

  always_comb begin
    ext_imm = '0;
    ext_err = 1'b0;
    case (bus.in_op)
      3'd0: ext_imm = XLEN'($signed(bus.in_din[24:13]));
      3'd1: begin
        if (XLEN == 64) ext_imm = XLEN'(bus.in_din[18:13]);
        else            ext_imm = XLEN'(bus.in_din[17:13]);
      end
      3'd2: ext_imm = XLEN'($signed({bus.in_din[24], bus.in_din[0], bus.in_din[23:18],
                                     bus.in_din[4:1], 1'b0}));
      3'd3: ext_imm = XLEN'($signed({bus.in_din[24:18], bus.in_din[4:0]}));
      3'd4: ext_imm = XLEN'($signed({bus.in_din[24:5], 12'b0}));
      3'd5: ext_imm = XLEN'($signed({bus.in_din[24], bus.in_din[12:5], bus.in_din[13],
                                     bus.in_din[23:14], 1'b0}));
      3'd6: ext_imm = XLEN'(bus.in_din[12:8]);
      default: begin
        ext_imm = '0;
        ext_err = 1'b1;
      end
    endcase
  end

  // Flush wins over everything, including a same-cycle accept.
  always_comb begin
    state_n       = state;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (bus.flush) begin
      state_n = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            load_out_in = 1'b1;
            state_n     = ONE;
          end
        end
        ONE: begin
          if (drain && accept) begin
            load_out_in = 1'b1;
          end else if (drain) begin
            state_n = EMPTY;
          end else if (accept) begin
            load_skid = 1'b1;
            state_n   = TWO;
          end
        end
        TWO: begin
          if (drain) begin
            load_out_skid = 1'b1;
            state_n       = ONE;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_imm_q  <= '0;
      out_tag_q  <= '0;
      out_err_q  <= 1'b0;
      skid_imm_q <= '0;
      skid_tag_q <= '0;
      skid_err_q <= 1'b0;
    end else begin
      if (load_out_in) begin
        out_imm_q <= ext_imm;
        out_tag_q <= bus.in_tag;
        out_err_q <= ext_err;
      end else if (load_out_skid) begin
        out_imm_q <= skid_imm_q;
        out_tag_q <= skid_tag_q;
        out_err_q <= skid_err_q;
      end
      if (load_skid) begin
        skid_imm_q <= ext_imm;
        skid_tag_q <= bus.in_tag;
        skid_err_q <= ext_err;
      end
    end
  end

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Parametrised, registered immediate extractor for RV32/RV64 cores. It accepts instruction bits [31:7] and a format code through a valid/ready handshake, and produces an XLEN-wide immediate one cycle later. A 2-entry output/skid buffer lets it sit between decode and execute without combinational ready paths. Compared with the plain combinational extender, it adds XLEN generalisation, RV64 6-bit shift amounts, CSR zimm, an illegal-format flag, a sideband tag and a synchronous flush.

## Interface
- XLEN, 32, immediate width; legal values 32 or 64.
- TAG_W, 4, width of the sideband tag carried alongside each immediate (≥1).
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous; drops all buffered entries.
- in_valid  input  1  input entry present.
- in_ready  output  1  block can accept; equals NOT skid_valid (registered source).
- in_op  input  3  format code.
- in_din  input  25  instruction bits [31:7]; in_din[k] = inst[k+7].
- in_tag  input  TAG_W  sideband, passed through unchanged.
- out_valid  output  1  output entry present.
- out_ready  input  1  consumer accepts.
- out_imm  output  XLEN  extracted immediate.
- out_tag  output  TAG_W  tag of the entry.
- out_err  output  1  entry had an illegal in_op.

## Operation
- Formats. s = in_din[24]. All sign extension replicates s up to XLEN.
  - 0: I-type, sext(din[24:13]).
  - 1: shamt. Zero-extended din[17:13] when XLEN=32; din[18:13] when XLEN=64.
  - 2: B-type, sext({din[24],din[0],din[23:18],din[4:1],0}).
  - 3: S-type, sext({din[24:18],din[4:0]}).
  - 4: U-type, {din[24:5],12'b0}, sign-extended from bit 31 when XLEN=64.
  - 5: J-type, sext({din[24],din[12:5],din[13],din[23:14],0}).
  - 6: CSR zimm, zero-extended din[12:8].
  - 7: illegal. imm=0, err=1.
- Err is 0 for ops 0–6.
- Storage: output register (out_valid, imm, tag, err) plus skid register (skid_valid, same fields).
- Accept happens when in_valid && in_ready. Drain happens when out_valid && out_ready.
- Per-cycle update, evaluated in priority order:
  - flush: out_valid←0, skid_valid←0. Any same-cycle accept is dropped. Data fields are don't-care.
  - Drain, skid full: output←skid, skid_valid←0.
  - Output empty or draining, accept: output←extract(input).
  - Output full and not draining, accept: skid←extract(input), skid_valid←1.
  - Drain with no refill: out_valid←0.
- Ordering: entries leave in acceptance order. Skid is never filled while the output is empty.
- XLEN values other than 32 or 64 are a configuration error. The block checks this at elaboration and stops.

## Timing
- Reset values: out_valid=0, skid_valid=0, in_ready=1, out_imm=0, out_tag=0, out_err=0.
- Latency: accept at edge N gives out_valid=1 with the result after edge N.
- Throughput: 1 per cycle while out_ready=1.
- in_ready does not depend combinationally on out_ready or in_valid.
- Back-pressure:
  - With out_ready=0, at most 2 entries are held. in_ready falls the cycle after the skid fills.
  - in_ready rises the cycle after the skid is moved into the output.
- Stability: while out_valid && !out_ready, out_imm, out_tag and out_err stay constant.
- Reset mid-operation clears both entries immediately; no partial entry is emitted.
- Flush in the same cycle as a drain: the drain counts as a transfer and nothing remains afterwards.

## Test plan
- Reset, then XLEN=32, op0, din=0x1FFE001 (addi -1), tag=3, out_ready=1:
  - next cycle out_imm=0xFFFFFFFF, out_tag=3, out_err=0.
  - cycle after, out_valid=0.
- XLEN=32, op2, din=0x1FC001D (beq -4) → 0xFFFFFFFC. op5, din from inst 0x0080006F (jal 8) → 0x00000008.
- XLEN=64:
  - op4, inst 0x800000B7 → 0xFFFFFFFF80000000.
  - op1 with inst[25:20]=0x21 → 0x21.
  - op6 with rs1 field=17 → 0x11.
  - op7 → imm 0, out_err=1.
- Back-pressure: out_ready=0, present tags 1,2,3 on consecutive cycles.
  - Tags 1 and 2 accepted; in_ready=0 while tag 3 is pending.
  - Raise out_ready: outputs 1,2,3 in order, and in_ready returns to 1 one cycle after the skid drains.
- Flush with two entries buffered plus a concurrent valid input:
  - next cycle out_valid=0, in_ready=1.
  - No entry appears afterwards.
- Assert rst asynchronously mid-stream with the skid full: outputs go to their reset values before the next clock edge.
